cf_spi_target: RTL and testbench



---
 rtl/cf_spi_target.sv | 176 +++++++++++++++++
 tb/tb_cf_spi_target.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_spi_target.sv
// SPI target core: oversamples sclk/csb/mosi in the system clock domain, shifts
// bytes out of a one-entry holding register and strobes each received byte.
module cf_spi_target #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          CPOL,
    input  logic          CPHA,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_underrun,
    output logic          busy,
    output logic          frame_done,
    input  logic          sclk,
    input  logic          csb,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, mosi_sync;
    logic [SYNC_STAGES:0]   settle;
    logic                   sclk_s, csb_s, mosi_s, sclk_d, csb_d, settled;
    logic                   csb_fall, csb_rise;
    logic                   cpol_l, cpha_l;
    logic                   frame_start, frame_end, active;
    logic                   lead, trail, sample, present, last_bit, slot_start;
    logic                   load, load_cpha;
    logic [CW-1:0]          bit_cnt;
    logic [DW-1:0]          tx_sh, hold_data, load_val, rx_next;
    logic [DW-2:0]          rx_sh;
    logic                   hold_full, und_pend, miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            csb_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b1;
            settle    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            csb_d     <= csb_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign csb_s   = csb_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    // Until the chain has refilled with real pin samples after reset, the
    // reset value of csb must not be mistaken for a falling edge.
    assign settled  = settle[SYNC_STAGES];
    assign csb_fall = settled && csb_d && !csb_s;
    assign csb_rise = !csb_d && csb_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && csb_fall) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (csb_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active     = (state == ACTIVE) && enable && !csb_rise;
    assign lead       = active && (sclk_d == cpol_l) && (sclk_s != cpol_l);
    assign trail      = active && (sclk_d != cpol_l) && (sclk_s == cpol_l);
    assign sample     = cpha_l ? trail : lead;
    assign last_bit   = sample && (bit_cnt == CW'(DW - 1));
    // In mode CPHA=0 the MSB of a new byte is presented by the load itself, so
    // the trailing edge right after the byte boundary must not shift again.
    assign present    = (cpha_l ? lead : trail) && (cpha_l || (bit_cnt != '0));
    assign slot_start = lead && (bit_cnt == '0);
    assign load       = frame_start || last_bit;
    assign load_cpha  = frame_start ? CPHA : cpha_l;
    assign load_val   = hold_full ? hold_data : '1;
    assign rx_next    = {rx_sh, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            miso_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_done  <= 1'b0;
            und_pend    <= 1'b0;
        end else begin
            rx_valid    <= last_bit;
            frame_done  <= frame_end;
            // A byte-end refill with ones only counts as an underrun once the
            // controller actually clocks into that slot.
            tx_underrun <= (frame_start && !hold_full) || (slot_start && und_pend);
            if (frame_start) begin
                cpol_l <= CPOL;
                cpha_l <= CPHA;
            end
            if (frame_start)  bit_cnt <= '0;
            else if (sample)  bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            if (sample)   rx_sh   <= rx_next[DW-2:0];
            if (last_bit) rx_data <= rx_next;
            if (load) begin
                if (!load_cpha) begin
                    miso_q <= load_val[DW-1];
                    tx_sh  <= load_val << 1;
                end else begin
                    tx_sh  <= load_val;
                end
            end else if (present) begin
                miso_q <= tx_sh[DW-1];
                tx_sh  <= tx_sh << 1;
            end
            if (last_bit)                           und_pend <= !hold_full;
            else if (slot_start || state != ACTIVE) und_pend <= 1'b0;
        end
    end

    // Disabled cores drop the holding register rather than keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (!enable) begin
            hold_full <= 1'b0;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

    assign tx_ready = !hold_full;
    assign busy     = (state == ACTIVE) && enable;
    assign miso_oe  = busy;
    assign miso     = busy && miso_q;

endmodule

// File: tb/tb_cf_spi_target.sv
// Self-checking bench for cf_spi_target: a bit-banged SPI controller, a host
// feeding the holding register, and a byte-level expectation model.
module tb_cf_spi_target;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n, enable, cpol, cpha, tx_valid, sclk, csb, mosi;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, tx_underrun, busy, frame_done, miso, miso_oe;
    logic [7:0] rx_data;

    int n_vec = 0;
    int n_err = 0;
    int cnt_rxv = 0, cnt_und = 0, cnt_fd = 0, cnt_dis = 0;
    logic [7:0] host_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mosi_bytes[8];
    logic [7:0] miso_bytes[8];
    logic [7:0] last_rx;

    always #5 clk = ~clk;

    cf_spi_target #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .CPOL(cpol), .CPHA(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .busy(busy), .frame_done(frame_done), .sclk(sclk), .csb(csb),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                cnt_rxv++;
                rx_q.push_back(rx_data);
            end
            if (tx_underrun) cnt_und++;
            if (frame_done) cnt_fd++;
            if (!enable && (rx_valid || tx_underrun || frame_done)) cnt_dis++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_loop();
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                tx_valid = 1'b0;
            end else if (host_q.size() > 0 && tx_ready) begin
                tx_data  = host_q.pop_front();
                tx_valid = 1'b1;
            end
        end
    endtask

    // Controller side: drives mosi_bytes, records what it samples into miso_bytes.
    task automatic spi_frame(input bit pol, input bit pha, input int nbytes,
                             input int nbits_lim, input bit scramble);
        int total;
        total = nbytes * 8;
        if (nbits_lim >= 0 && nbits_lim < total) total = nbits_lim;
        cpol = pol;
        cpha = pha;
        sclk = pol;
        wait_n(H);
        mosi = mosi_bytes[0][7];
        csb  = 1'b0;
        for (int b = 0; b < total; b++) begin
            int by = b / 8;
            int bi = 7 - (b % 8);
            if (!pha) begin
                wait_n(H);
                if (scramble && b == 0) begin
                    cpol = 1'($urandom());
                    cpha = 1'($urandom());
                end
                miso_bytes[by][bi] = miso;
                sclk = ~pol;
                wait_n(H);
                sclk = pol;
                if (b + 1 < total) mosi = mosi_bytes[(b + 1) / 8][7 - ((b + 1) % 8)];
            end else begin
                wait_n(H);
                if (scramble && b == 0) begin
                    cpol = 1'($urandom());
                    cpha = 1'($urandom());
                end
                sclk = ~pol;
                mosi = mosi_bytes[by][bi];
                wait_n(H);
                miso_bytes[by][bi] = miso;
                sclk = pol;
            end
        end
        wait_n(H);
        csb = 1'b1;
        wait_n(2 * H);
    endtask

    task automatic test_reset();
        logic [14:0] got;
        #2;
        got = {tx_ready, rx_valid, rx_data, tx_underrun, frame_done, busy, miso, miso_oe};
        n_vec++;
        if (got !== 15'h4000) begin
            n_err++;
            $display("FAIL reset_values: got %b want %b", got, 15'h4000);
        end
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);
        n_vec++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b tx_ready=%b want 0/1", busy, tx_ready);
        end
        last_rx = 8'h00;
    endtask

    task automatic test_mode(input bit pol, input bit pha);
        int rb = rx_q.size();
        int r0 = cnt_rxv, u0 = cnt_und, f0 = cnt_fd;
        logic [7:0] got;
        host_q.push_back(8'hA5);
        mosi_bytes[0] = 8'h3C;
        spi_frame(pol, pha, 1, -1, 1'b1);
        n_vec++;
        if (miso_bytes[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL mode%0d_miso: got %h want a5", {pol, pha}, miso_bytes[0]);
        end
        got = (rx_q.size() > rb) ? rx_q[rb] : 8'hxx;
        n_vec++;
        if (cnt_rxv - r0 !== 1 || got !== 8'h3C) begin
            n_err++;
            $display("FAIL mode%0d_rx: got %0d pulses data %h want 1 pulse data 3c", {pol, pha}, cnt_rxv - r0, got);
        end
        n_vec++;
        if (cnt_fd - f0 !== 1 || cnt_und - u0 !== 0) begin
            n_err++;
            $display("FAIL mode%0d_strobes: got done=%0d underrun=%0d want 1/0", {pol, pha}, cnt_fd - f0, cnt_und - u0);
        end
        last_rx = 8'h3C;
    endtask

    // Reference: slot i carries host byte i if the host had one, else all ones;
    // every slot without host data is one underrun; every full byte one rx strobe.
    task automatic run_frame_check(input string name, input bit pol, input bit pha,
                                   input int nb, input int k, input logic [7:0] hb[4]);
        int rb = rx_q.size();
        int r0 = cnt_rxv, u0 = cnt_und, f0 = cnt_fd;
        logic [7:0] want, got;
        for (int i = 0; i < k; i++) host_q.push_back(hb[i]);
        spi_frame(pol, pha, nb, -1, 1'b0);
        for (int i = 0; i < nb; i++) begin
            want = (i < k) ? hb[i] : 8'hFF;
            n_vec++;
            if (miso_bytes[i] !== want) begin
                n_err++;
                $display("FAIL %s_miso%0d: got %h want %h", name, i, miso_bytes[i], want);
            end
            got = (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx;
            n_vec++;
            if (got !== mosi_bytes[i]) begin
                n_err++;
                $display("FAIL %s_rx%0d: got %h want %h", name, i, got, mosi_bytes[i]);
            end
        end
        n_vec++;
        if (cnt_rxv - r0 !== nb || cnt_und - u0 !== nb - k || cnt_fd - f0 !== 1) begin
            n_err++;
            $display("FAIL %s_counts: got rx=%0d und=%0d done=%0d want %0d/%0d/1",
                     name, cnt_rxv - r0, cnt_und - u0, cnt_fd - f0, nb, nb - k);
        end
        last_rx = mosi_bytes[nb - 1];
    endtask

    task automatic test_back_to_back();
        logic [7:0] hb[4];
        hb = '{8'h10, 8'h20, 8'h30, 8'h00};
        mosi_bytes[0] = 8'h01;
        mosi_bytes[1] = 8'h02;
        mosi_bytes[2] = 8'h03;
        run_frame_check("b2b", 1'($urandom()), 1'($urandom()), 3, 3, hb);
    endtask

    task automatic test_underrun();
        logic [7:0] hb[4];
        hb = '{8'h00, 8'h00, 8'h00, 8'h00};
        mosi_bytes[0] = 8'h55;
        run_frame_check("underrun", 1'($urandom()), 1'($urandom()), 1, 0, hb);
    endtask

    task automatic test_abort();
        int r0 = cnt_rxv, f0 = cnt_fd;
        logic [7:0] hb[4];
        mosi_bytes[0] = 8'($urandom());
        spi_frame(1'($urandom()), 1'($urandom()), 1, 5, 1'b0);
        n_vec++;
        if (cnt_rxv - r0 !== 0 || cnt_fd - f0 !== 1) begin
            n_err++;
            $display("FAIL abort_strobes: got rx=%0d done=%0d want 0/1", cnt_rxv - r0, cnt_fd - f0);
        end
        n_vec++;
        if (rx_data !== last_rx) begin
            n_err++;
            $display("FAIL abort_rx_hold: got %h want %h", rx_data, last_rx);
        end
        hb = '{8'h00, 8'h00, 8'h00, 8'h00};
        mosi_bytes[0] = 8'h81;
        run_frame_check("abort_recover", 1'($urandom()), 1'($urandom()), 1, 0, hb);
    endtask

    task automatic test_enable_drop();
        int r0 = cnt_rxv, u0 = cnt_und, f0 = cnt_fd, d0 = cnt_dis;
        host_q.push_back(8'($urandom()));
        host_q.push_back(8'($urandom()));
        mosi_bytes[0] = 8'($urandom());
        fork
            spi_frame(1'b0, 1'b0, 1, -1, 1'b0);
            begin
                int t = 0;
                while (!(busy === 1'b1 && tx_ready === 1'b0) && t < 400) begin
                    wait_n(1);
                    t++;
                end
                n_vec++;
                if (t >= 400) begin
                    n_err++;
                    $display("FAIL enable_refill_wait: got timeout want refill mid-frame");
                end
                wait_n(6 * H);
                enable = 1'b0;
                #1;
                n_vec++;
                if ({busy, miso_oe, miso} !== 3'b000) begin
                    n_err++;
                    $display("FAIL enable_drop_outputs: got %b want 000", {busy, miso_oe, miso});
                end
                wait_n(1);
                n_vec++;
                if (tx_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL enable_flush: got tx_ready=%b want 1", tx_ready);
                end
            end
        join
        n_vec++;
        if (cnt_rxv != r0 || cnt_und != u0 || cnt_fd != f0 || cnt_dis != d0) begin
            n_err++;
            $display("FAIL enable_no_strobes: got rx=%0d und=%0d done=%0d want 0/0/0",
                     cnt_rxv - r0, cnt_und - u0, cnt_fd - f0);
        end
        enable = 1'b1;
        wait_n(2);
    endtask

    task automatic test_reset_mid();
        int r0 = 0, u0 = 0, f0 = 0;
        logic [14:0] got;
        logic [7:0] hb[4];
        mosi_bytes[0] = 8'($urandom());
        fork
            spi_frame(1'($urandom()), 1'($urandom()), 1, -1, 1'b0);
            begin
                wait_n(5 * H);
                #3;
                rst_n = 1'b0;
                #1;
                got = {tx_ready, rx_valid, rx_data, tx_underrun, frame_done, busy, miso, miso_oe};
                n_vec++;
                if (got !== 15'h4000) begin
                    n_err++;
                    $display("FAIL reset_mid_values: got %b want %b", got, 15'h4000);
                end
                wait_n(1);
                rst_n = 1'b1;
                r0 = cnt_rxv;
                u0 = cnt_und;
                f0 = cnt_fd;
                wait_n(2 * H);
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_no_restart: got busy=%b want 0", busy);
                end
            end
        join
        n_vec++;
        if (cnt_rxv != r0 || cnt_und != u0 || cnt_fd != f0) begin
            n_err++;
            $display("FAIL reset_no_strobes: got rx=%0d und=%0d done=%0d want 0/0/0",
                     cnt_rxv - r0, cnt_und - u0, cnt_fd - f0);
        end
        last_rx = 8'h00;
        hb = '{8'($urandom()), 8'h00, 8'h00, 8'h00};
        mosi_bytes[0] = 8'($urandom());
        run_frame_check("reset_recover", 1'($urandom()), 1'($urandom()), 1, 1, hb);
    endtask

    task automatic test_random();
        logic [7:0] hb[4];
        for (int it = 0; it < 6; it++) begin
            int nb = int'($urandom_range(4, 1));
            int k  = int'($urandom_range(nb, 0));
            for (int i = 0; i < 4; i++) begin
                hb[i]         = 8'($urandom());
                mosi_bytes[i] = 8'($urandom());
            end
            run_frame_check("random", 1'($urandom()), 1'($urandom()), nb, k, hb);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sclk     = 1'b0;
        csb      = 1'b1;
        mosi     = 1'b0;
        last_rx  = 8'h00;
        fork
            host_loop();
        join_none
        test_reset();
        for (int m = 0; m < 4; m++) test_mode(m[1], m[0]);
        test_back_to_back();
        test_underrun();
        test_abort();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
